// File: rtl/i2c_pkg.sv
// ============================================================================
// i2c_pkg : shared state codes and bus constants for the I2C responder
// Rev 1.0
// ============================================================================
`default_nettype none

package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_RX_BYTE   = 3'd3,
    ST_RX_ACK    = 3'd4,
    ST_TX_BYTE   = 3'd5,
    ST_TX_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_state_e;

  // Sub-phase inside an acknowledge slot.
  typedef enum logic [1:0] {
    ACK_IDLE  = 2'd0,
    ACK_DRIVE = 2'd1,
    ACK_HOLD  = 2'd2
  } ack_step_e;

  localparam logic I2C_RD = 1'b1;
  localparam logic I2C_WR = 1'b0;
  localparam logic ACK    = 1'b0;
  localparam logic NACK   = 1'b1;

  function automatic logic addr_match(input logic [7:0] rx_byte, input logic [6:0] own_addr);
    return rx_byte[7:1] == own_addr;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_line_filter.sv
// ============================================================================
// i2c_line_filter : synchronizer, glitch filter and edge flags for one bus line
// Rev 1.0
// ============================================================================
`default_nettype none

module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [2:0] CNT_MAX = 3'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   w_sync_shift;
  logic                   w_synced;
  logic [2:0]             cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign w_sync_shift = {sync_q, i_line};
  assign w_synced     = sync_q[SYNC_STAGES-1];

  // The filtered level only moves after FILTER_LEN samples that all disagree with it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (w_synced != level_q) begin
      if (cnt_q == CNT_MAX) level_d = w_synced;
      else                  cnt_d   = cnt_q + 3'd1;
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= w_sync_shift[SYNC_STAGES-1:0];
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

endmodule

`default_nettype wire

// File: rtl/i2c_slave_responder.sv
// ============================================================================
// i2c_slave_responder : oversampling I2C target with address match, RX and TX
// Rev 1.0
// ============================================================================
`default_nettype none

module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic       PT_CK,
  input  logic       RESET_N,
  input  logic [7:0] SLAVE_ADDRESS,
  input  logic       SCLI,
  input  logic       SDAI,
  output logic       SDAO,
  input  logic [7:0] TX_DATA,
  output logic       TX_REQ,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       ADDR_HIT,
  output logic       RD_MODE,
  output logic [7:0] BYTE_CNT,
  output logic       BUSY,
  output logic       END_OK,
  output logic [3:0] ST
);

  logic scl, scl_r, scl_f;
  logic sda, sda_r, sda_f;
  logic w_start, w_stop;
  logic [7:0] w_shift_in;
  logic unused_addr_lsb;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk     (PT_CK),
    .rst_n   (RESET_N),
    .i_line  (SCLI),
    .o_level (scl),
    .o_rise  (scl_r),
    .o_fall  (scl_f)
  );

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk     (PT_CK),
    .rst_n   (RESET_N),
    .i_line  (SDAI),
    .o_level (sda),
    .o_rise  (sda_r),
    .o_fall  (sda_f)
  );

  i2c_state_e state_q, state_d;
  ack_step_e  ack_step_q, ack_step_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       sdao_q, sdao_d;
  logic       rd_mode_q, rd_mode_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic       busy_q, busy_d;
  logic       matched_q, matched_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       addr_hit_q, addr_hit_d;
  logic       tx_req_q, tx_req_d;
  logic       end_ok_q, end_ok_d;

  assign unused_addr_lsb = SLAVE_ADDRESS[0];
  assign w_start    = sda_f & scl;
  assign w_stop     = sda_r & scl;
  assign w_shift_in = {shift_q[6:0], sda};

  always_comb begin
    state_d    = state_q;
    ack_step_d = ack_step_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sdao_d     = sdao_q;
    rd_mode_d  = rd_mode_q;
    byte_cnt_d = byte_cnt_q;
    busy_d     = busy_q;
    matched_d  = matched_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    addr_hit_d = 1'b0;
    tx_req_d   = 1'b0;
    end_ok_d   = 1'b0;

    if (w_start) begin
      state_d    = ST_ADDR;
      ack_step_d = ACK_IDLE;
      bit_cnt_d  = '0;
      busy_d     = 1'b1;
      sdao_d     = 1'b1;
      byte_cnt_d = '0;
      matched_d  = 1'b0;
    end else if (w_stop) begin
      state_d    = ST_IDLE;
      ack_step_d = ACK_IDLE;
      busy_d     = 1'b0;
      sdao_d     = 1'b1;
      end_ok_d   = matched_q;
      matched_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: sdao_d = 1'b1;

        ST_ADDR: begin
          if (scl_r) begin
            shift_d = w_shift_in;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (addr_match(w_shift_in, SLAVE_ADDRESS[7:1])) begin
                rd_mode_d  = w_shift_in[0];
                addr_hit_d = 1'b1;
                matched_d  = 1'b1;
                ack_step_d = ACK_IDLE;
                state_d    = ST_ADDR_ACK;
              end else begin
                sdao_d  = 1'b1;
                state_d = ST_WAIT_STOP;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        // Pull low on the first fall, hold across the 9th clock, release on the next fall.
        ST_ADDR_ACK, ST_RX_ACK: begin
          unique case (ack_step_q)
            ACK_IDLE: if (scl_f) begin
              sdao_d     = ACK;
              ack_step_d = ACK_DRIVE;
            end
            ACK_DRIVE: if (scl_r) ack_step_d = ACK_HOLD;
            default: if (scl_f) begin
              ack_step_d = ACK_IDLE;
              bit_cnt_d  = '0;
              if (state_q == ST_RX_ACK || rd_mode_q == I2C_WR) begin
                sdao_d  = 1'b1;
                state_d = ST_RX_BYTE;
              end else begin
                tx_req_d  = 1'b1;
                shift_d   = TX_DATA;
                sdao_d    = TX_DATA[7];
                bit_cnt_d = 4'd1;
                state_d   = ST_TX_BYTE;
              end
            end
          endcase
        end

        ST_RX_BYTE: begin
          if (scl_r) begin
            shift_d = w_shift_in;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d  = '0;
              rx_data_d  = w_shift_in;
              rx_valid_d = 1'b1;
              byte_cnt_d = byte_cnt_q + 8'd1;
              ack_step_d = ACK_IDLE;
              state_d    = ST_RX_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        // bit_cnt counts bits already placed on SDAO.
        ST_TX_BYTE: begin
          if (scl_f) begin
            if (bit_cnt_q == 4'd8) begin
              sdao_d     = 1'b1;
              ack_step_d = ACK_IDLE;
              state_d    = ST_TX_ACK;
            end else begin
              sdao_d    = shift_q[6];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        ST_TX_ACK: begin
          if (ack_step_q == ACK_IDLE) begin
            if (scl_r) begin
              byte_cnt_d = byte_cnt_q + 8'd1;
              if (sda == ACK) ack_step_d = ACK_HOLD;
              else begin
                sdao_d  = 1'b1;
                state_d = ST_WAIT_STOP;
              end
            end
          end else if (scl_f) begin
            ack_step_d = ACK_IDLE;
            tx_req_d   = 1'b1;
            shift_d    = TX_DATA;
            sdao_d     = TX_DATA[7];
            bit_cnt_d  = 4'd1;
            state_d    = ST_TX_BYTE;
          end
        end

        default: sdao_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      ack_step_q <= ACK_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      sdao_q     <= 1'b1;
      rd_mode_q  <= 1'b0;
      byte_cnt_q <= '0;
      busy_q     <= 1'b0;
      matched_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      addr_hit_q <= 1'b0;
      tx_req_q   <= 1'b0;
      end_ok_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_step_q <= ack_step_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      sdao_q     <= sdao_d;
      rd_mode_q  <= rd_mode_d;
      byte_cnt_q <= byte_cnt_d;
      busy_q     <= busy_d;
      matched_q  <= matched_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      addr_hit_q <= addr_hit_d;
      tx_req_q   <= tx_req_d;
      end_ok_q   <= end_ok_d;
    end
  end

  assign SDAO     = sdao_q;
  assign TX_REQ   = tx_req_q;
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign ADDR_HIT = addr_hit_q;
  assign RD_MODE  = rd_mode_q;
  assign BYTE_CNT = byte_cnt_q;
  assign BUSY     = busy_q;
  assign END_OK   = end_ok_q;
  assign ST       = {1'b0, state_q};

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_responder.sv
// ============================================================================
// tb_i2c_slave_responder : directed bit-banged master with RX/TX scoreboards
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_i2c_slave_responder;

  localparam int Q = 20;  // system clocks per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] slave_addr = 8'h90;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] tx_data = 8'h00;
  wire        sda_bus;

  wire        sdao, tx_req, rx_valid, addr_hit, rd_mode, busy, end_ok;
  wire [7:0]  rx_data, byte_cnt;
  wire [3:0]  st;

  assign sda_bus = m_sda & sdao;

  always #5 clk = ~clk;

  i2c_slave_responder dut (
    .PT_CK         (clk),
    .RESET_N       (rst_n),
    .SLAVE_ADDRESS (slave_addr),
    .SCLI          (m_scl),
    .SDAI          (sda_bus),
    .SDAO          (sdao),
    .TX_DATA       (tx_data),
    .TX_REQ        (tx_req),
    .RX_DATA       (rx_data),
    .RX_VALID      (rx_valid),
    .ADDR_HIT      (addr_hit),
    .RD_MODE       (rd_mode),
    .BYTE_CNT      (byte_cnt),
    .BUSY          (busy),
    .END_OK        (end_ok),
    .ST            (st)
  );

  int vectors = 0;
  int miscompares = 0;
  int n_rxv = 0, n_txreq = 0, n_hit = 0, n_endok = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      n_rxv++;
      if (rx_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL rx_unexpected: observed %0h expected none", rx_data);
      end else begin
        chk("rx_data", {24'h0, rx_data}, {24'h0, rx_q.pop_front()});
      end
    end
    if (tx_req === 1'b1)   n_txreq++;
    if (addr_hit === 1'b1) n_hit++;
    if (end_ok === 1'b1)   n_endok++;
  end

  task automatic wq();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic start_c();
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b0; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic stop_c();
    m_sda = 1'b0; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b1; wq();
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    wq();
    m_scl = 1'b1; wq();
    wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    b = sda_bus;  wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_data(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;

    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_sdao",  {31'h0, sdao}, 32'h1);
    chk("reset_st",    {28'h0, st}, 32'h0);
    chk("reset_busy",  {31'h0, busy}, 32'h0);
    chk("reset_cnt",   {24'h0, byte_cnt}, 32'h0);
    chk("reset_rx",    {24'h0, rx_data}, 32'h0);
    chk("reset_rd",    {31'h0, rd_mode}, 32'h0);

    // Write 0xA5, 0x3C to own address
    start_c();
    chk("t1_busy", {31'h0, busy}, 32'h1);
    write_byte(8'h90, ack); chk("t1_ack_addr", {31'h0, ack}, 32'h0);
    chk("t1_hits", n_hit, 1);
    rx_q.push_back(8'hA5);
    write_byte(8'hA5, ack); chk("t1_ack_d0", {31'h0, ack}, 32'h0);
    rx_q.push_back(8'h3C);
    write_byte(8'h3C, ack); chk("t1_ack_d1", {31'h0, ack}, 32'h0);
    stop_c();
    chk("t1_rxv",   n_rxv, 2);
    chk("t1_cnt",   {24'h0, byte_cnt}, 32'h2);
    chk("t1_endok", n_endok, 1);
    chk("t1_st",    {28'h0, st}, 32'h0);
    chk("t1_busy0", {31'h0, busy}, 32'h0);
    chk("t1_rd",    {31'h0, rd_mode}, 32'h0);

    // Read two bytes, ACK then NACK
    tx_data = 8'h5A; tx_q.push_back(8'h5A);
    start_c();
    write_byte(8'h91, ack); chk("t2_ack_addr", {31'h0, ack}, 32'h0);
    chk("t2_rd", {31'h0, rd_mode}, 32'h1);
    read_data(rd);
    chk("t2_byte0", {24'h0, rd}, {24'h0, tx_q.pop_front()});
    tx_data = 8'hC3; tx_q.push_back(8'hC3);
    write_bit(1'b0);
    read_data(rd);
    chk("t2_byte1", {24'h0, rd}, {24'h0, tx_q.pop_front()});
    write_bit(1'b1);
    chk("t2_sdao_nack", {31'h0, sdao}, 32'h1);
    chk("t2_st_wait",   {28'h0, st}, 32'h7);
    chk("t2_txreq",     n_txreq, 2);
    chk("t2_cnt",       {24'h0, byte_cnt}, 32'h2);
    stop_c();
    chk("t2_endok", n_endok, 2);

    // Foreign address
    start_c();
    write_byte(8'h92, ack); chk("t3_nack", {31'h0, ack}, 32'h1);
    chk("t3_hits", n_hit, 2);
    chk("t3_st",   {28'h0, st}, 32'h7);
    write_byte(8'h55, ack);
    chk("t3_st2",  {28'h0, st}, 32'h7);
    stop_c();
    chk("t3_st0",  {28'h0, st}, 32'h0);
    chk("t3_endok", n_endok, 2);

    // Write then repeated START into a read
    start_c();
    write_byte(8'h90, ack); chk("t4_ack_addr", {31'h0, ack}, 32'h0);
    rx_q.push_back(8'h11);
    write_byte(8'h11, ack); chk("t4_ack_d", {31'h0, ack}, 32'h0);
    chk("t4_cnt1", {24'h0, byte_cnt}, 32'h1);
    start_c();
    chk("t4_cnt0", {24'h0, byte_cnt}, 32'h0);
    chk("t4_st_addr", {28'h0, st}, 32'h1);
    tx_data = 8'h77; tx_q.push_back(8'h77);
    write_byte(8'h91, ack); chk("t4_ack_rd", {31'h0, ack}, 32'h0);
    read_data(rd);
    chk("t4_byte", {24'h0, rd}, {24'h0, tx_q.pop_front()});
    write_bit(1'b1);
    stop_c();
    chk("t4_rxv",   n_rxv, 3);
    chk("t4_hits",  n_hit, 4);
    chk("t4_txreq", n_txreq, 3);
    chk("t4_endok", n_endok, 3);

    // STOP in the middle of a data byte
    start_c();
    write_byte(8'h90, ack); chk("t5_ack_addr", {31'h0, ack}, 32'h0);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    stop_c();
    chk("t5_st",   {28'h0, st}, 32'h0);
    chk("t5_busy", {31'h0, busy}, 32'h0);
    chk("t5_sdao", {31'h0, sdao}, 32'h1);
    chk("t5_rxv",  n_rxv, 3);
    chk("t5_rx",   {24'h0, rx_data}, 32'h11);

    // Reset while the address ACK of a read holds SDA low
    start_c();
    for (int i = 7; i >= 0; i--) write_bit(rd_bit_of_91(i));
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    chk("t6_sdao_low", {31'h0, sdao}, 32'h0);
    chk("t6_rd",       {31'h0, rd_mode}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_sdao_rel", {31'h0, sdao}, 32'h1);
    chk("t6_st",       {28'h0, st}, 32'h0);
    chk("t6_rd0",      {31'h0, rd_mode}, 32'h0);
    chk("t6_rx0",      {24'h0, rx_data}, 32'h0);
    chk("t6_busy",     {31'h0, busy}, 32'h0);
    chk("t6_cnt",      {24'h0, byte_cnt}, 32'h0);
    chk("t6_pulses",   {28'h0, tx_req, rx_valid, addr_hit, end_ok}, 32'h0);
    m_scl = 1'b1; m_sda = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    wq();
    chk("t6_st_after", {28'h0, st}, 32'h0);
    chk("rx_q_drained", rx_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  function automatic logic rd_bit_of_91(input int i);
    logic [7:0] v;
    v = 8'h91;
    return v[i];
  endfunction

endmodule

`default_nettype wire

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- I2C target (slave) that answers the same bit-banged I2C bus our masters drive; the other end of the I2C read-command master.
- Oversamples SCL/SDA on the system clock, detects START/STOP, and matches the 7-bit address.
- Write transfers: ACKs each byte and hands it upstream.
- Read transfers: shifts out bytes supplied upstream until the master NACKs.
- Never drives SCL; no clock stretching.

Parameters:
SYNC_STAGES, 2, synchronizer flops on SCLI and SDAI
FILTER_LEN, 3, consecutive identical synchronized samples required before a filtered line level changes (2..7)

Ports:
PT_CK  input  1  system clock; one clock; at least 16x the SCL rate
RESET_N  input  1  reset, asynchronous and active-low
SLAVE_ADDRESS  input  8  bits[7:1] = own 7-bit address; bit0 ignored
SCLI  input  1  raw bus SCL
SDAI  input  1  raw bus SDA
SDAO  output  1  open-drain SDA control: 1 = release, 0 = pull low
TX_DATA  input  8  next read byte; sampled on the PT_CK cycle TX_REQ is high
TX_REQ  output  1  1-cycle pulse: TX_DATA captured, upstream may advance
RX_DATA  output  8  last byte received in a write transfer
RX_VALID  output  1  1-cycle pulse with a new RX_DATA
ADDR_HIT  output  1  1-cycle pulse on address match
RD_MODE  output  1  R/W bit of the current matched transfer
BYTE_CNT  output  8  data bytes completed in the current transfer; wraps 255->0
BUSY  output  1  high from START to STOP
END_OK  output  1  1-cycle pulse when STOP ends a matched transfer
ST  output  4  state code, for test

Behaviour:
- Reset (async assert, sync release): SDAO=1, all pulses 0, RX_DATA=0, RD_MODE=0, BYTE_CNT=0, BUSY=0, ST=IDLE(0); filters preset to 1.
- Front end: SYNC_STAGES flops, then FILTER_LEN filter, giving scl/sda. Edges are single-cycle flags scl_r/scl_f.
- START: sda falls while scl=1. STOP: sda rises while scl=1. Both are detected in every state.
- START in any state, including repeated START: state->ADDR, bit count=0, BUSY=1, SDAO=1 next cycle, BYTE_CNT=0.
- STOP in any state: state->IDLE, BUSY=0, SDAO=1; END_OK pulses if a match occurred since the last START.
- Bus timing: SDA is sampled on scl_r; SDAO changes only on the cycle after scl_f.
- States (ST code):
- IDLE(0): wait for START.
- ADDR(1): shift 8 bits MSB first on scl_r. After the 8th bit:
  - match ([7:1]==SLAVE_ADDRESS[7:1]): latch RD_MODE, pulse ADDR_HIT, go to ADDR_ACK.
  - mismatch: go to WAIT_STOP with SDAO=1.
- ADDR_ACK(2): on next scl_f, SDAO=0. Hold through one scl_r, release on the following scl_f.
  - Write: go to RX_BYTE.
  - Read: pulse TX_REQ and load the shifter in the same cycle as the release, put MSB on SDAO, go to TX_BYTE.
- RX_BYTE(3): shift 8 bits on scl_r; after the 8th bit, RX_DATA<=byte, pulse RX_VALID, increment BYTE_CNT, go to RX_ACK.
- RX_ACK(4): drive ACK as in ADDR_ACK, then return to RX_BYTE.
- TX_BYTE(5): on each scl_f present the next bit; after the 8th bit's scl_f, SDAO=1, go to TX_ACK.
- TX_ACK(6): on scl_r sample the master's bit.
  - 0 (ACK): increment BYTE_CNT, pulse TX_REQ and load on the next scl_f, back to TX_BYTE.
  - 1 (NACK): increment BYTE_CNT, go to WAIT_STOP.
- WAIT_STOP(7): SDAO=1; leave only on STOP or START.
- Simultaneous events: START/STOP take priority over data-bit handling on the same cycle. SDAO is always 1 outside ACK and TX drive windows.
- Mid-operation reset: SDAO releases immediately (asynchronous), so the bus is never held low.

Decomposition:
- Shared package i2c_pkg: state encodings (IDLE..WAIT_STOP), I2C_RD=1'b1 / I2C_WR=1'b0, ACK=1'b0 / NACK=1'b1.
- One sub-module, i2c_line_filter: synchronizer + FILTER_LEN filter + edge flags, instantiated for SCL and SDA.

Test Plan:
- SLAVE_ADDRESS=8'h90, master writes 0x90,0xA5,0x3C then STOP -> ACK on all 3 bytes; RX_VALID x2 with 0xA5 then 0x3C; BYTE_CNT=2; END_OK pulses once.
- Master sends 0x91, reads 2 bytes (ACK then NACK), TX_DATA=0x5A then 0xC3 -> bus shows 0x5A,0xC3; TX_REQ x2; RD_MODE=1; SDAO=1 after NACK.
- Address 0x92 while SLAVE_ADDRESS=0x90 -> no ACK (SDA high on 9th clock); ADDR_HIT never pulses; ST=7 until STOP.
- Write 0x90,0x11, then repeated START + 0x91, read 1 byte NACK -> RX 0x11, then read path; BYTE_CNT resets to 0 at the repeated START.
- STOP inserted after 4 bits of a data byte -> ST=0, BUSY=0, SDAO=1, no RX_VALID.
- Assert RESET_N=0 during a read ACK slot where SDAO=0 -> SDAO=1 in the same cycle; all outputs at reset values.
